mandel_iter_ctrl: RTL and testbench
===================================

# mandel_iter_ctrl

Per-pixel iteration controller for the pipelined Mandelbrot datapath. It sits directly downstream of the add stage and closes the loop back to the multiply stage. It accepts one pixel coordinate c, issues z to the multiply stage and collects aa-bb, 2ab and the diverged flag from the add stage. It then forms z_next = z² + c, repeats until escape or MAX_ITER, and returns the iteration count through a valid/ready handshake.

## Interface
- MAX_ITER, 255, maximum number of z updates per pixel; must fit in ITER_W bits.
- ITER_W, 8, width of the iteration counter and of iter_count.
- LAT, 2, number of register stages between the issue outputs and the return inputs (multiply stage plus add stage).
- aclk  in  1  clock; all state updates on the rising edge.
- arst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  pixel coordinate offered.
- in_ready  out  1  block can accept a coordinate (high only in IDLE).
- c_re, c_im  in  32  pixel coordinate, Q4.28 two's complement.
- z_re_o, z_im_o  out  32  current z to the multiply stage (registered).
- a0_o, b0_o  out  32  c_re / c_im forwarded alongside z (registered).
- ld_o  out  1  first-issue marker; the upstream pipeline carries it aligned with the products to the add stage's ld.
- aa_minus_bb  in  32  returned Re(z²).
- twoab  in  32  returned Im(z²).
- a0_ret, b0_ret  in  32  returned c_re / c_im.
- diverged  in  1  returned escape flag (aa+bb > 4.0).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- iter_count  out  ITER_W  z updates completed before escape, or MAX_ITER.
- escaped  out  1  1 = diverged, 0 = hit MAX_ITER.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: in_ready=1. When in_valid=1, capture c and set z_re_o=z_im_o=0, a0_o=c_re, b0_o=c_im, ld_o=1 and iter=0. Load the wait counter and go to WAIT.
- WAIT: count LAT cycles, then sample the return ports on the next edge.
- On the sample edge, if diverged=1: iter_count=iter, escaped=1, go to DONE.
- On the sample edge, otherwise: iter=iter+1.
  - If the new iter equals MAX_ITER: iter_count=MAX_ITER, escaped=0, go to DONE.
  - Otherwise set z_re_o=aa_minus_bb+a0_ret and z_im_o=twoab+b0_ret, set ld_o=0, reload the wait counter and stay in WAIT.
- The first return after ld_o=1 is always all-zero with diverged=0, so it yields z=c and iter=1.
- Arithmetic: 32-bit two's-complement add with wrap; no saturation; no other width change.
- DONE: out_valid=1. iter_count and escaped are held stable until out_ready=1, then go to IDLE.
- in_valid is ignored outside IDLE.
- In DONE with out_ready=1 and in_valid=1 in the same cycle, the block goes to IDLE. The coordinate is accepted no earlier than the following cycle.

## Timing
- Reset (async, immediate):
  - state=IDLE, in_ready=1.
  - z_re_o, z_im_o, a0_o, b0_o, ld_o, out_valid, iter_count and escaped all 0.
  - Wait counter and iter cleared.
- arst asserted mid-pixel abandons that pixel. Results still in flight upstream are ignored because the block is in IDLE.
- Issue outputs change on edge E0. The return ports are sampled on edge E0+LAT+1, which is also the edge that drives the next issue. One iteration therefore takes LAT+1 cycles.
- Accept edge to first sample: LAT+1 cycles.
- A pixel escaping with iter_count=N reaches DONE (N+1)·(LAT+1) cycles after the accept edge. A non-escaping pixel reaches DONE MAX_ITER·(LAT+1) cycles after the accept edge.
- out_valid rises on the edge entering DONE. It falls on the edge where out_valid=1 and out_ready=1 are both high.
- ld_o is high only for the first issue period and falls on the first sample edge.

## Test plan
- Escape: c=(0x28000000, 0) = 2.5, with a behavioural upstream model at LAT=2 -> out_valid after 6 cycles, iter_count=1, escaped=1.
- Bounded: c=(0,0) -> iter_count=255, escaped=0, out_valid 765 cycles after accept; z_re_o and z_im_o stay 0 throughout.
- Slow escape: c=(0x04000000, 0x10000000) = (0.25, 1.0) -> iter_count equals the reference-model count, escaped=1. Each z_re_o/z_im_o matches the model bit-exactly, including 32-bit wrap.
- Handshake:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0.
  - Then assert out_ready together with in_valid -> IDLE next cycle; new coordinate accepted one cycle later.
- Reset: assert arst mid-WAIT at iteration 3 -> all outputs 0 immediately and in_ready=1. After release, a new c=2.5 gives iter_count=1.
- Ignore: pulse in_valid with a different c during WAIT -> no effect on a0_o/b0_o or on the result.

Source files
------------

// File: rtl/mandel_iter_ctrl.sv
// Per-pixel Mandelbrot iteration controller: issues z to the multiply/add
// pipeline, closes the z = z^2 + c loop and reports the escape iteration count.
module mandel_iter_ctrl #(
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8,
    parameter int LAT      = 2
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       c_re,
    input  logic [31:0]       c_im,
    output logic [31:0]       z_re_o,
    output logic [31:0]       z_im_o,
    output logic [31:0]       a0_o,
    output logic [31:0]       b0_o,
    output logic              ld_o,
    input  logic [31:0]       aa_minus_bb,
    input  logic [31:0]       twoab,
    input  logic [31:0]       a0_ret,
    input  logic [31:0]       b0_ret,
    input  logic              diverged,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] iter_count,
    output logic              escaped
);

    localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(LAT);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ITER_W-1:0] ITER_ZERO = ITER_W'(0);
    localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   wait_cnt_r;
    logic [ITER_W-1:0]  iter_r;
    logic [31:0]        z_re_r;
    logic [31:0]        z_im_r;
    logic [31:0]        a0_r;
    logic [31:0]        b0_r;
    logic               ld_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [ITER_W-1:0]  iter_count_r;
    logic               escaped_r;

    logic [31:0]        z_re_next_s;
    logic [31:0]        z_im_next_s;
    logic [ITER_W-1:0]  iter_inc_s;

    // Next z and iteration count, formed from the values returned by the add stage
    always_comb begin
        z_re_next_s = aa_minus_bb + a0_ret;
        z_im_next_s = twoab + b0_ret;
        iter_inc_s  = iter_r + ITER_ONE;
    end

    // Iteration FSM: accept, wait out the pipeline latency, sample, update or finish
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= CNT_ZERO;
            iter_r       <= ITER_ZERO;
            z_re_r       <= 32'd0;
            z_im_r       <= 32'd0;
            a0_r         <= 32'd0;
            b0_r         <= 32'd0;
            ld_r         <= 1'b0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            iter_count_r <= ITER_ZERO;
            escaped_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        z_re_r     <= 32'd0;
                        z_im_r     <= 32'd0;
                        a0_r       <= c_re;
                        b0_r       <= c_im;
                        ld_r       <= 1'b1;
                        iter_r     <= ITER_ZERO;
                        wait_cnt_r <= WAIT_LOAD;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r != CNT_ZERO) begin
                        wait_cnt_r <= wait_cnt_r - CNT_ONE;
                    end else if (diverged) begin
                        // The returned flag belongs to the z issued last, so iter is final
                        ld_r         <= 1'b0;
                        iter_count_r <= iter_r;
                        escaped_r    <= 1'b1;
                        out_valid_r  <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        ld_r   <= 1'b0;
                        iter_r <= iter_inc_s;
                        if (iter_inc_s == ITER_MAX) begin
                            iter_count_r <= ITER_MAX;
                            escaped_r    <= 1'b0;
                            out_valid_r  <= 1'b1;
                            state_r      <= ST_DONE;
                        end else begin
                            z_re_r     <= z_re_next_s;
                            z_im_r     <= z_im_next_s;
                            wait_cnt_r <= WAIT_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    ld_r        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign z_re_o     = z_re_r;
    assign z_im_o     = z_im_r;
    assign a0_o       = a0_r;
    assign b0_o       = b0_r;
    assign ld_o       = ld_r;
    assign out_valid  = out_valid_r;
    assign iter_count = iter_count_r;
    assign escaped    = escaped_r;

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
// Scoreboard bench for mandel_iter_ctrl with a behavioural two-stage
// multiply/add upstream model closing the loop.
module tb_mandel_iter_ctrl;

    localparam int LAT      = 2;
    localparam int ITER_W   = 8;
    localparam int MAX_ITER = 255;

    logic              aclk;
    logic              arst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       c_re;
    logic [31:0]       c_im;
    logic [31:0]       z_re_o;
    logic [31:0]       z_im_o;
    logic [31:0]       a0_o;
    logic [31:0]       b0_o;
    logic              ld_o;
    logic [31:0]       aa_minus_bb;
    logic [31:0]       twoab;
    logic [31:0]       a0_ret;
    logic [31:0]       b0_ret;
    logic              diverged;
    logic              out_valid;
    logic              out_ready;
    logic [ITER_W-1:0] iter_count;
    logic              escaped;

    mandel_iter_ctrl #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .LAT(LAT)) dut (
        .aclk(aclk), .arst(arst), .in_valid(in_valid), .in_ready(in_ready),
        .c_re(c_re), .c_im(c_im), .z_re_o(z_re_o), .z_im_o(z_im_o),
        .a0_o(a0_o), .b0_o(b0_o), .ld_o(ld_o),
        .aa_minus_bb(aa_minus_bb), .twoab(twoab), .a0_ret(a0_ret), .b0_ret(b0_ret),
        .diverged(diverged), .out_valid(out_valid), .out_ready(out_ready),
        .iter_count(iter_count), .escaped(escaped)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Q4.28 multiply, full precision kept in 64 bits
    function automatic longint qmul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p >>> 28;
    endfunction

    // Upstream model: stage 1 multiplies, stage 2 adds and flags escape
    longint      s1_aa, s1_bb, s1_ab;
    logic [31:0] s1_a0, s1_b0;
    logic        s1_ld;
    always @(posedge aclk) begin
        s1_aa <= qmul(z_re_o, z_re_o);
        s1_bb <= qmul(z_im_o, z_im_o);
        s1_ab <= qmul(z_re_o, z_im_o);
        s1_a0 <= a0_o;
        s1_b0 <= b0_o;
        s1_ld <= ld_o;
    end
    always @(posedge aclk) begin
        if (s1_ld) begin
            aa_minus_bb <= 32'd0;
            twoab       <= 32'd0;
            diverged    <= 1'b0;
        end else begin
            aa_minus_bb <= 32'(s1_aa - s1_bb);
            twoab       <= 32'(64'sd2 * s1_ab);
            diverged    <= (s1_aa + s1_bb) > 64'sd1073741824;
        end
        a0_ret <= s1_a0;
        b0_ret <= s1_b0;
    end

    typedef struct { logic [ITER_W-1:0] cnt; logic esc; int lat; } res_t;
    typedef struct { logic [31:0] zr; logic [31:0] zi; logic [31:0] a0; logic [31:0] b0; logic ld; } iss_t;
    res_t res_q[$];
    iss_t iss_q[$];

    // Expected result (hand values) plus the reference sequence of issued z
    task automatic push_exp(input logic [31:0] cr, input logic [31:0] ci,
                            input int cnt, input logic esc, input int lat);
        res_t   r;
        iss_t   s;
        logic [31:0] zr, zi, nr, ni;
        longint aa, bb, ab;
        int     it;
        r.cnt = ITER_W'(cnt);
        r.esc = esc;
        r.lat = lat;
        res_q.push_back(r);
        zr = 32'd0;
        zi = 32'd0;
        it = 0;
        for (int k = 0; k < MAX_ITER + 1; k++) begin
            s.zr = zr; s.zi = zi; s.a0 = cr; s.b0 = ci; s.ld = (k == 0);
            iss_q.push_back(s);
            aa = qmul(zr, zr);
            bb = qmul(zi, zi);
            ab = qmul(zr, zi);
            if ((aa + bb) > 64'sd1073741824) break;
            it++;
            if (it == MAX_ITER) break;
            nr = 32'(aa - bb) + cr;
            ni = 32'(64'sd2 * ab) + ci;
            zr = nr;
            zi = ni;
        end
    endtask

    // Tracks cycles since the accept edge of the pixel in flight
    logic trk;
    int   phase;
    always @(posedge aclk or posedge arst) begin
        if (arst) begin
            trk   <= 1'b0;
            phase <= 0;
        end else if (in_valid && in_ready) begin
            trk   <= 1'b1;
            phase <= 0;
        end else if (trk && out_valid) begin
            trk <= 1'b0;
        end else begin
            phase <= phase + 1;
        end
    end

    // Monitor: compares each issue and each result against the scoreboard
    always @(negedge aclk) begin
        res_t r;
        iss_t s;
        if (!arst && trk) begin
            if (out_valid) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    r = res_q.pop_front();
                    chk("iter_count", 32'(iter_count), 32'(r.cnt));
                    chk("escaped", 32'(escaped), 32'(r.esc));
                    chk("latency", 32'(phase), 32'(r.lat));
                end
            end else if (phase % (LAT + 1) == 0) begin
                if (iss_q.size() == 0) begin
                    chk("unexpected_issue", 32'd1, 32'd0);
                end else begin
                    s = iss_q.pop_front();
                    chk("z_re_o", z_re_o, s.zr);
                    chk("z_im_o", z_im_o, s.zi);
                    chk("a0_o", a0_o, s.a0);
                    chk("b0_o", b0_o, s.b0);
                    chk("ld_o", 32'(ld_o), 32'(s.ld));
                end
            end
        end
    end

    task automatic chk_reset_state();
        chk("rst_z_re", z_re_o, 32'd0);
        chk("rst_z_im", z_im_o, 32'd0);
        chk("rst_a0", a0_o, 32'd0);
        chk("rst_b0", b0_o, 32'd0);
        chk("rst_ld", 32'(ld_o), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_iter_count", 32'(iter_count), 32'd0);
        chk("rst_escaped", 32'(escaped), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [31:0] cr, input logic [31:0] ci);
        @(negedge aclk);
        c_re = cr;
        c_im = ci;
        in_valid = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (in_ready) begin
                @(negedge aclk);
                in_valid = 1'b0;
                return;
            end
            @(negedge aclk);
        end
        in_valid = 1'b0;
        chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 2000; k++) begin
            @(negedge aclk);
            if (res_q.size() == 0 && in_ready && !out_valid) return;
        end
        chk("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst      = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c_re      = 32'd0;
        c_im      = 32'd0;
        repeat (3) @(negedge aclk);
        chk_reset_state();
        arst = 1'b0;

        // Fast escape at 2.5
        push_exp(32'h28000000, 32'h00000000, 1, 1'b1, 6);
        send(32'h28000000, 32'h00000000);
        wait_done();

        // Origin never escapes
        push_exp(32'h00000000, 32'h00000000, 255, 1'b0, 765);
        send(32'h00000000, 32'h00000000);
        wait_done();

        // |z|^2 of exactly 4.0 is not an escape; c = 2i escapes one step later
        push_exp(32'h00000000, 32'h20000000, 2, 1'b1, 9);
        send(32'h00000000, 32'h20000000);
        wait_done();

        // c = -2 sits on the fixed point z = 2 with |z|^2 = 4.0
        push_exp(32'hE0000000, 32'h00000000, 255, 1'b0, 765);
        send(32'hE0000000, 32'h00000000);
        wait_done();

        // Slow escape with a stray in_valid pulse during WAIT
        push_exp(32'h04000000, 32'h10000000, 4, 1'b1, 15);
        send(32'h04000000, 32'h10000000);
        repeat (4) @(negedge aclk);
        c_re = 32'h12345678;
        c_im = 32'h07654321;
        in_valid = 1'b1;
        @(negedge aclk);
        in_valid = 1'b0;
        chk("ignore_a0", a0_o, 32'h04000000);
        chk("ignore_b0", b0_o, 32'h10000000);
        wait_done();

        // Back-pressure in DONE, then release together with a new coordinate
        out_ready = 1'b0;
        push_exp(32'h28000000, 32'h00000000, 1, 1'b1, 6);
        send(32'h28000000, 32'h00000000);
        for (int k = 0; k < 50; k++) begin
            if (out_valid) break;
            @(negedge aclk);
        end
        for (int k = 0; k < 10; k++) begin
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_iter_count", 32'(iter_count), 32'd1);
            chk("hold_escaped", 32'(escaped), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge aclk);
        end
        push_exp(32'h00000000, 32'h20000000, 2, 1'b1, 9);
        c_re = 32'h00000000;
        c_im = 32'h20000000;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge aclk);
        chk("hs_idle_out_valid", 32'(out_valid), 32'd0);
        chk("hs_idle_in_ready", 32'(in_ready), 32'd1);
        @(negedge aclk);
        in_valid = 1'b0;
        chk("hs_accept_in_ready", 32'(in_ready), 32'd0);
        chk("hs_accept_b0", b0_o, 32'h20000000);
        chk("hs_accept_ld", 32'(ld_o), 32'd1);
        wait_done();

        // Reset in the middle of iteration 3
        push_exp(32'h00000000, 32'h00000000, 255, 1'b0, 765);
        send(32'h00000000, 32'h00000000);
        repeat (10) @(negedge aclk);
        arst = 1'b1;
        #1;
        chk_reset_state();
        res_q.delete();
        iss_q.delete();
        repeat (2) @(negedge aclk);
        arst = 1'b0;
        push_exp(32'h28000000, 32'h00000000, 1, 1'b1, 6);
        send(32'h28000000, 32'h00000000);
        wait_done();

        chk("res_q_drained", 32'(res_q.size()), 32'd0);
        chk("iss_q_drained", 32'(iss_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
